// File: rtl/osc_bank_pkg.sv
// Shared definitions for the time-multiplexed oscillator bank:
// configuration select encodings and control-word bit positions.
package osc_bank_pkg;

   typedef enum logic [1:0] {
      SEL_PERIOD0 = 2'd0,
      SEL_PERIOD1 = 2'd1,
      SEL_CTRL    = 2'd2,
      SEL_RSVD    = 2'd3
   } cfg_sel_e;

   // Control word layout carried in cfg_data[1:0]
   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_ONESHOT_BIT = 1;

endpackage

// File: rtl/osc_bank_if.sv
// Configuration / trigger bus of the oscillator bank.
// master = controller side, slave = osc_bank side.
interface osc_bank_if #(
   parameter int NUM_CH      = 4,
   parameter int PERIOD_BITS = 8
);
   localparam int CW = $clog2(NUM_CH);

   logic                   cfg_we;
   logic [CW-1:0]          cfg_ch;
   logic [1:0]             cfg_sel;
   logic [PERIOD_BITS-1:0] cfg_data;
   logic                   sync;
   logic                   trig_valid;
   logic [CW-1:0]          trig_ch;
   logic [NUM_CH-1:0]      trig_flags;
   logic [NUM_CH-1:0]      trig_clr;

   modport master (
      output cfg_we, cfg_ch, cfg_sel, cfg_data, sync, trig_clr,
      input  trig_valid, trig_ch, trig_flags
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_sel, cfg_data, sync, trig_clr,
      output trig_valid, trig_ch, trig_flags
   );
endinterface

// File: rtl/osc_bank_osc_step.sv
// osc_step: per-visit arithmetic of one oscillator channel. Purely
// combinational; a single instance is shared by all channels of the bank.
// A disarmed or disabled channel holds its counter.
module osc_step #(
   parameter int PERIOD_BITS = 8,
   parameter int LOG2_STEP   = 0
) (
   input  logic [PERIOD_BITS-1:0] counter,
   input  logic [PERIOD_BITS-1:0] period0,
   input  logic [PERIOD_BITS-1:0] period1,
   input  logic                   enable,
   input  logic                   armed,
   output logic                   trigger,
   output logic [PERIOD_BITS-1:0] next
);
   localparam logic [PERIOD_BITS-1:0] STEP =
      {{(PERIOD_BITS-1){1'b0}}, 1'b1} << LOG2_STEP;

   // Trigger when the counter bits above the step granularity are all zero,
   // then reload with the selected period minus one step (wrapping).
   always_comb begin
      trigger = enable & armed & (counter[PERIOD_BITS-1:LOG2_STEP] == '0);
      if (enable & armed) begin
         next = counter + (trigger ? period1 : period0) - STEP;
      end else begin
         next = counter;
      end
   end
endmodule

// File: rtl/osc_bank.sv
// osc_bank: NUM_CH time-multiplexed oscillator channels visited round-robin,
// one channel per clock. Optional one-shot support is compiled in with the
// macro OSC_BANK_ONESHOT_EN; without it every channel free-runs.
module osc_bank
   import osc_bank_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int PERIOD_BITS = 8,
   parameter int LOG2_STEP   = 0
) (
   input  logic     clk,
   input  logic     reset,
   osc_bank_if.slave bus
);
   localparam int CW = $clog2(NUM_CH);

   logic [NUM_CH-1:0][PERIOD_BITS-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0][PERIOD_BITS-1:0] p0_q, p0_d;
   logic [NUM_CH-1:0][PERIOD_BITS-1:0] p1_q, p1_d;
   logic [NUM_CH-1:0]                  en_q, en_d;
   logic [NUM_CH-1:0]                  flags_q, flags_d;
   logic [NUM_CH-1:0]                  armed_v;
   logic [CW-1:0]                      scan_q, scan_d;
   logic [CW-1:0]                      trig_ch_q, trig_ch_d;
   logic                               trig_valid_q, trig_valid_d;
   logic                               step_trig_s;
   logic [PERIOD_BITS-1:0]             step_next_s;

`ifdef OSC_BANK_ONESHOT_EN
   logic [NUM_CH-1:0] os_q, os_d;
   logic [NUM_CH-1:0] armed_q, armed_d;
   assign armed_v = armed_q;
`else
   assign armed_v = '1;
`endif

   osc_step #(
      .PERIOD_BITS (PERIOD_BITS),
      .LOG2_STEP   (LOG2_STEP)
   ) u_step (
      .counter (cnt_q[scan_q]),
      .period0 (p0_q[scan_q]),
      .period1 (p1_q[scan_q]),
      .enable  (en_q[scan_q]),
      .armed   (armed_v[scan_q]),
      .trigger (step_trig_s),
      .next    (step_next_s)
   );

   assign bus.trig_valid = trig_valid_q;
   assign bus.trig_ch    = trig_ch_q;
   assign bus.trig_flags = flags_q;

   // Next-state: visit update, sync override, then configuration writes.
   always_comb begin
      cnt_d        = cnt_q;
      p0_d         = p0_q;
      p1_d         = p1_q;
      en_d         = en_q;
      flags_d      = flags_q & ~bus.trig_clr;
      trig_valid_d = 1'b0;
      trig_ch_d    = trig_ch_q;
`ifdef OSC_BANK_ONESHOT_EN
      os_d         = os_q;
      armed_d      = armed_q;
`endif
      if (scan_q == CW'(NUM_CH - 1)) begin
         scan_d = '0;
      end else begin
         scan_d = scan_q + CW'(1);
      end

      // Visit of the current channel (uses pre-write register values)
      cnt_d[scan_q] = step_next_s;

      if (bus.sync) begin
         // sync zeroes every counter, re-arms, and hides this visit's trigger
         cnt_d = '0;
`ifdef OSC_BANK_ONESHOT_EN
         armed_d = '1;
`endif
      end else if (step_trig_s) begin
         trig_valid_d    = 1'b1;
         trig_ch_d       = scan_q;
         flags_d[scan_q] = 1'b1;
`ifdef OSC_BANK_ONESHOT_EN
         if (os_q[scan_q]) begin
            armed_d[scan_q] = 1'b0;
         end else begin
            armed_d[scan_q] = armed_q[scan_q];
         end
`endif
      end else begin
         trig_valid_d = 1'b0;
      end

      if (bus.cfg_we) begin
         case (bus.cfg_sel)
            SEL_PERIOD0: p0_d[bus.cfg_ch] = bus.cfg_data;
            SEL_PERIOD1: p1_d[bus.cfg_ch] = bus.cfg_data;
            SEL_CTRL: begin
               en_d[bus.cfg_ch] = bus.cfg_data[CTRL_EN_BIT];
`ifdef OSC_BANK_ONESHOT_EN
               os_d[bus.cfg_ch] = bus.cfg_data[CTRL_ONESHOT_BIT];
               if (bus.cfg_data[CTRL_EN_BIT]) begin
                  armed_d[bus.cfg_ch] = 1'b1;
               end else begin
                  armed_d[bus.cfg_ch] = armed_d[bus.cfg_ch];
               end
`endif
            end
            default: begin
               // reserved select: write ignored
            end
         endcase
      end else begin
         p0_d = p0_d;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         p0_q         <= '0;
         p1_q         <= '0;
         en_q         <= '0;
         flags_q      <= '0;
         scan_q       <= '0;
         trig_ch_q    <= '0;
         trig_valid_q <= 1'b0;
`ifdef OSC_BANK_ONESHOT_EN
         os_q         <= '0;
         armed_q      <= '1;
`endif
      end else begin
         cnt_q        <= cnt_d;
         p0_q         <= p0_d;
         p1_q         <= p1_d;
         en_q         <= en_d;
         flags_q      <= flags_d;
         scan_q       <= scan_d;
         trig_ch_q    <= trig_ch_d;
         trig_valid_q <= trig_valid_d;
`ifdef OSC_BANK_ONESHOT_EN
         os_q         <= os_d;
         armed_q      <= armed_d;
`endif
      end
   end
endmodule

// File: tb/tb_osc_bank.sv
// Directed self-checking bench for osc_bank. A second instance with
// LOG2_STEP=2 covers the coarse-step counter behaviour. One-shot
// expectations follow OSC_BANK_ONESHOT_EN.
module tb_osc_bank;
   import osc_bank_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   osc_bank_if #(.NUM_CH(4), .PERIOD_BITS(8)) bus  ();
   osc_bank_if #(.NUM_CH(4), .PERIOD_BITS(8)) bus2 ();

   osc_bank #(.NUM_CH(4), .PERIOD_BITS(8), .LOG2_STEP(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   osc_bank #(.NUM_CH(4), .PERIOD_BITS(8), .LOG2_STEP(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel, input logic [7:0] data);
      bus.cfg_ch   = ch;
      bus.cfg_sel  = sel;
      bus.cfg_data = data;
      bus.cfg_we   = 1'b1;
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   task automatic cfg_write2(input logic [1:0] ch, input logic [1:0] sel, input logic [7:0] data);
      bus2.cfg_ch   = ch;
      bus2.cfg_sel  = sel;
      bus2.cfg_data = data;
      bus2.cfg_we   = 1'b1;
      tick();
      bus2.cfg_we   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if (bus.trig_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.trig_valid); end
      total++;
      if (bus.trig_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", bus.trig_ch); end
      total++;
      if (bus.trig_flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0", bus.trig_flags); end
   endtask

   // ch0 period1=3: first visit triggers, then every 3rd visit (12 cycles)
   task automatic test_basic();
      logic exp;
      do_reset();
      cfg_write(2'd0, SEL_PERIOD1, 8'd3);
      cfg_write(2'd0, SEL_CTRL, 8'd1);
      for (int t = 1; t <= 40; t++) begin
         tick();
         exp = ((t % 12) == 3);
         total++;
         if (bus.trig_valid !== exp) begin bad++; $display("FAIL basic_valid t=%0d got=%b exp=%b", t, bus.trig_valid, exp); end
         if (exp) begin
            total++;
            if (bus.trig_ch !== 2'd0) begin bad++; $display("FAIL basic_ch t=%0d got=%0d exp=0", t, bus.trig_ch); end
         end
      end
      total++;
      if (bus.trig_flags !== 4'b0001) begin bad++; $display("FAIL basic_flags got=%b exp=0001", bus.trig_flags); end
   endtask

   // four channels period1=1..4: intervals 4,8,12,16 cycles
   task automatic test_multi();
      int  c;
      int  k;
      logic exp;
      do_reset();
      for (int i = 0; i < 4; i++) cfg_write(2'(i), SEL_PERIOD1, 8'(i + 1));
      for (int i = 0; i < 4; i++) cfg_write(2'(i), SEL_CTRL, 8'd1);
      for (int t = 1; t <= 48; t++) begin
         tick();
         c   = (t - 1) % 4;
         k   = (t - 1) / 4;
         exp = ((k % (c + 1)) == 0);
         total++;
         if (bus.trig_valid !== exp) begin bad++; $display("FAIL multi_valid t=%0d got=%b exp=%b", t, bus.trig_valid, exp); end
         if (exp) begin
            total++;
            if (bus.trig_ch !== 2'(c)) begin bad++; $display("FAIL multi_ch t=%0d got=%0d exp=%0d", t, bus.trig_ch, c); end
         end
      end
      total++;
      if (bus.trig_flags !== 4'hF) begin bad++; $display("FAIL multi_flags got=%b exp=1111", bus.trig_flags); end
   endtask

   // LOG2_STEP=2, period1=8: counter 0->4->0, trigger every 2 visits
   task automatic test_step();
      logic exp;
      do_reset();
      cfg_write2(2'd0, SEL_PERIOD1, 8'd8);
      cfg_write2(2'd0, SEL_CTRL, 8'd1);
      for (int t = 1; t <= 32; t++) begin
         tick();
         exp = (t >= 3) && (((t - 3) % 8) == 0);
         total++;
         if (bus2.trig_valid !== exp) begin bad++; $display("FAIL step_valid t=%0d got=%b exp=%b", t, bus2.trig_valid, exp); end
      end
   endtask

   // trig_clr coinciding with a set: set wins; next cycle clear takes effect
   task automatic test_flag_clr();
      do_reset();
      cfg_write(2'd2, SEL_PERIOD1, 8'd3);
      cfg_write(2'd2, SEL_CTRL, 8'd1);
      bus.trig_clr = 4'b0100;
      tick();
      total++;
      if (bus.trig_valid !== 1'b1 || bus.trig_ch !== 2'd2) begin bad++; $display("FAIL clr_trig got=%b/%0d exp=1/2", bus.trig_valid, bus.trig_ch); end
      total++;
      if (bus.trig_flags[2] !== 1'b1) begin bad++; $display("FAIL clr_setwins got=%b exp=1", bus.trig_flags[2]); end
      tick();
      total++;
      if (bus.trig_flags[2] !== 1'b0) begin bad++; $display("FAIL clr_clear got=%b exp=0", bus.trig_flags[2]); end
      bus.trig_clr = 4'b0000;
   endtask

   // sync zeroes counters and suppresses a coinciding trigger
   task automatic test_sync();
      logic exp;
      do_reset();
      cfg_write(2'd0, SEL_PERIOD1, 8'd3);
      cfg_write(2'd0, SEL_CTRL, 8'd1);
      tick();
      tick();
      bus.sync = 1'b1;
      tick();
      bus.sync = 1'b0;
      total++;
      if (bus.trig_valid !== 1'b0) begin bad++; $display("FAIL sync_suppress got=%b exp=0", bus.trig_valid); end
      total++;
      if (bus.trig_flags !== 4'h0) begin bad++; $display("FAIL sync_flags got=%b exp=0000", bus.trig_flags); end
      for (int t = 1; t <= 4; t++) begin
         tick();
         exp = (t == 4);
         total++;
         if (bus.trig_valid !== exp) begin bad++; $display("FAIL sync_after t=%0d got=%b exp=%b", t, bus.trig_valid, exp); end
      end
      tick();
      bus.sync = 1'b1;
      tick();
      bus.sync = 1'b0;
      for (int t = 1; t <= 2; t++) begin
         tick();
         exp = (t == 2);
         total++;
         if (bus.trig_valid !== exp) begin bad++; $display("FAIL sync_zero t=%0d got=%b exp=%b", t, bus.trig_valid, exp); end
      end
   endtask

   // ch1 oneshot: one trigger, one more after sync (free-runs without macro)
   task automatic test_oneshot();
      int n;
      int exp_n;
`ifdef OSC_BANK_ONESHOT_EN
      exp_n = 1;
`else
      exp_n = 5;
`endif
      do_reset();
      cfg_write(2'd1, SEL_PERIOD1, 8'd2);
      cfg_write(2'd1, SEL_CTRL, 8'd3);
      n = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (bus.trig_valid === 1'b1 && bus.trig_ch === 2'd1) n++;
         if (t == 4) begin
            total++;
            if (bus.trig_valid !== 1'b1 || bus.trig_ch !== 2'd1) begin bad++; $display("FAIL os_first got=%b/%0d exp=1/1", bus.trig_valid, bus.trig_ch); end
         end
      end
      total++;
      if (n !== exp_n) begin bad++; $display("FAIL os_count1 got=%0d exp=%0d", n, exp_n); end
      bus.sync = 1'b1;
      tick();
      bus.sync = 1'b0;
      n = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (bus.trig_valid === 1'b1 && bus.trig_ch === 2'd1) n++;
      end
      total++;
      if (n !== exp_n) begin bad++; $display("FAIL os_count2 got=%0d exp=%0d", n, exp_n); end
`ifdef OSC_BANK_ONESHOT_EN
      cfg_write(2'd1, SEL_CTRL, 8'd3);
      n = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (bus.trig_valid === 1'b1 && bus.trig_ch === 2'd1) n++;
      end
      total++;
      if (n !== 1) begin bad++; $display("FAIL os_rearm got=%0d exp=1", n); end
`endif
   endtask

   // reset mid-scan with flags set; a same-cycle write is ignored
   task automatic test_reset_mid();
      total++;
      if (bus.trig_flags === 4'h0) begin bad++; $display("FAIL mid_pre got=%b exp=nonzero", bus.trig_flags); end
      tick();
      reset = 1'b1;
      bus.cfg_ch   = 2'd0;
      bus.cfg_sel  = SEL_CTRL;
      bus.cfg_data = 8'd1;
      bus.cfg_we   = 1'b1;
      bus.sync     = 1'b1;
      tick();
      reset = 1'b0;
      bus.cfg_we = 1'b0;
      bus.sync   = 1'b0;
      total++;
      if (bus.trig_valid !== 1'b0 || bus.trig_ch !== 2'd0 || bus.trig_flags !== 4'h0) begin
         bad++; $display("FAIL mid_outputs got=%b/%0d/%b exp=0/0/0000", bus.trig_valid, bus.trig_ch, bus.trig_flags);
      end
      cfg_write(2'd1, SEL_CTRL, 8'd1);
      total++;
      if (bus.trig_valid !== 1'b0) begin bad++; $display("FAIL mid_ch0_idle got=%b exp=0", bus.trig_valid); end
      tick();
      total++;
      if (bus.trig_valid !== 1'b1 || bus.trig_ch !== 2'd1) begin bad++; $display("FAIL mid_scan0 got=%b/%0d exp=1/1", bus.trig_valid, bus.trig_ch); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.cfg_we  = 1'b0; bus.cfg_ch  = '0; bus.cfg_sel  = 2'd0; bus.cfg_data  = '0; bus.sync  = 1'b0; bus.trig_clr  = '0;
      bus2.cfg_we = 1'b0; bus2.cfg_ch = '0; bus2.cfg_sel = 2'd0; bus2.cfg_data = '0; bus2.sync = 1'b0; bus2.trig_clr = '0;
      test_reset();
      test_basic();
      test_step();
      test_flag_clr();
      test_sync();
      test_oneshot();
      test_multi();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
